pipeline_control: RTL and testbench
===================================

# pipeline_control

Five-stage successor to the single-cycle control decoder. It decodes the full RV32I base set in Decode and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages. It resolves all six branch conditions, JAL and JALR in Execute, and generates the stall, flush and forwarding signals for the pipelined datapath. It sits beside the datapath: the instruction comes in from the IF/ID register, the branch flags come in from the Execute ALU, and stage-aligned controls go out to each stage.

## Interface
Parameters:
- FORWARDING, default 1: 1 = bypass-based hazard handling; 0 = pure interlock, with ForwardAE/BE tied to 00.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instrD  in  32  instruction in Decode
- ZeroE  in  1  ALU result equal to zero (Execute)
- LtE  in  1  signed rs1 < rs2 (Execute)
- LtuE  in  1  unsigned rs1 < rs2 (Execute)
- ImmSrcD  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
- IllegalD  out  1  opcode or funct not in RV32I subset
- ALUControlE  out  4  ALU operation
- ALUSrcAE  out  1  operand A source: 0 = rs1, 1 = PC
- ALUSrcBE  out  1  operand B source: 0 = rs2, 1 = immediate
- PCSrcE  out  2  next PC: 00 = PC+4, 01 = PC+imm, 10 = ALU result
- MemWriteM  out  1  data-memory write enable
- AddressingControlM  out  3  load/store width (funct3)
- RegWriteW  out  1  register-file write enable
- ResultSrcW  out  2  writeback source: 00 = ALU, 01 = memory, 10 = PC+4
- StallF, StallD  out  1 each  hold PC and the IF/ID register
- FlushD  out  1  clear the IF/ID register
- ForwardAE, ForwardBE  out  2 each  operand bypass: 00 = register file, 01 = W, 10 = M

## Operation
ALU encoding:
- 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
- 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1011 sra.
- 1001 pass-B (used by LUI).

Decode (combinational, D stage):
- R-type, I-ALU, load, store, branch, JAL, JALR, LUI and AUIPC.
- AUIPC: ALUSrcA = 1, ALUSrcB = 1, add.
- Branches: ALU performs sub.
- Any unlisted opcode, funct3 or funct7: IllegalD = 1 and the bundle is forced to a bubble (RegWrite = MemWrite = 0, PCSrc = 00).

Branch resolution (E stage):
- Taken when: beq ZeroE, bne !ZeroE, blt LtE, bge !LtE, bltu LtuE, bgeu !LtuE.
- Taken branch or JAL: PCSrcE = 01. JALR: PCSrcE = 10.

Hazard logic:
- Load-use: ResultSrcE = 01 and rdE ≠ 0 and rdE matches rs1D or rs2D → StallF = StallD = 1 and a bubble is inserted into E.
- Interlock (FORWARDING = 0): any RegWrite stage in E/M/W with rd ≠ 0 matching rs1D or rs2D → same stall and bubble.
- Forwarding, rs1E:
  - 10 if RegWriteM and rdM ≠ 0 and rdM = rs1E.
  - Else 01 if RegWriteW and rdW ≠ 0 and rdW = rs1E.
  - Else 00.
- ForwardBE uses the same rules with rs2E.
- rs1/rs2 of stores and branches are bypassed the same way.

Control transfer:
- PCSrcE ≠ 00 → FlushD = 1 and a bubble is inserted into E on the next edge.
- Simultaneous redirect and stall: the redirect wins. StallF = StallD = 0 and FlushD = 1.
- Register indices are not checked for rs fields the opcode does not use (e.g. rs2 of an I-type). Spurious stalls on those are permitted; false bypasses are harmless.

## Timing
- Decode outputs (ImmSrcD, IllegalD) are combinational from instrD.
- Each stage control is registered once per stage: the D bundle appears on E outputs 1 cycle later, on M 2 cycles later, on W 3 cycles later.
- Stall and flush outputs are combinational from the current stage registers and instrD.
- A load-use stall lasts exactly 1 cycle with FORWARDING = 1.
- An interlock stall with FORWARDING = 0 lasts up to 3 cycles.
- Reset: all stage registers clear to bubble immediately when rst rises, without waiting for a clock edge. Every registered output reads 0. All stall, flush and forward outputs read 0.
- Reset asserted mid-instruction: an in-flight store must not write (MemWriteM drops without waiting for a clock edge).

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams;
  - ALUControl, ImmSrc, ResultSrc and PCSrc encodings;
  - a packed `ctrl_bundle_t` struct;
  - the `BUBBLE` constant.
- One sub-module, `ctrl_decoder`: the purely combinational opcode/funct → bundle decoder.
- The stage registers, branch resolution and hazard/forward logic live in the top level.

## Test plan
- lw x5,0(x1) (0x0000A283), then add x6,x5,x2 (0x00228333) → one cycle of StallF = StallD = 1 and a bubble in E; when add reaches E, ForwardAE = 01.
- beq x1,x2,8 (0x00208463) in E with ZeroE = 1 → PCSrcE = 01 and FlushD = 1. With ZeroE = 0 → PCSrcE = 00 and no flush.
- lui x7,0x12345 (0x123453B7) → ImmSrcD = 100; 1 cycle later ALUControlE = 1001; 3 cycles later RegWriteW = 1 and ResultSrcW = 00.
- Back-to-back add x3,x1,x2 then sub x4,x3,x3 → ForwardAE = ForwardBE = 10. Repeat with FORWARDING = 0 → StallD held for 3 cycles.
- Assert rst asynchronously while sw sits in M → MemWriteM = 0 before the next clock edge; all outputs 0.
- instrD = 0xFFFFFFFF → IllegalD = 1; the E bundle is all-zero on the next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings, control bundle types and helpers for pipeline_control
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Full decode bundle carried from D into E
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [3:0] alu_control;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_bundle_t;

    // Subset still needed once the instruction has left Execute
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] funct3;
        logic [4:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic [4:0] rd;
    } wb_ctrl_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // ALU operation from funct3; alt selects sub/sra
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // A writing stage whose non-zero rd matches a source register
    function automatic logic rd_hits(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
        return wr && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational RV32I opcode/funct to control bundle decoder
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t bundle_o,
    output logic [2:0]   imm_src_o,
    output logic         illegal_o
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_bundle_t b;
    logic [2:0]   imm;
    logic         ill;

    assign op = instr_i[6:0];
    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];

    // Decode the instruction; anything outside RV32I collapses to a bubble
    always_comb begin
        b      = BUBBLE;
        imm    = IMM_I;
        ill    = 1'b0;
        b.funct3 = f3;
        b.rd     = instr_i[11:7];
        b.rs1    = instr_i[19:15];
        b.rs2    = instr_i[24:20];
        case (op)
            OP_R: begin
                b.reg_write   = 1'b1;
                b.alu_control = alu_op(f3, f7[5]);
                if (f7 != 7'b0 && !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    ill = 1'b1;
            end
            OP_I: begin
                b.reg_write   = 1'b1;
                b.alu_src_b   = 1'b1;
                b.alu_control = alu_op(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001 && f7 != 7'b0)
                    ill = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000)
                    ill = 1'b1;
            end
            OP_LOAD: begin
                b.reg_write   = 1'b1;
                b.result_src  = RES_MEM;
                b.alu_src_b   = 1'b1;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                    ill = 1'b1;
            end
            OP_STORE: begin
                b.mem_write   = 1'b1;
                b.alu_src_b   = 1'b1;
                imm           = IMM_S;
                if (f3 > 3'b010)
                    ill = 1'b1;
            end
            OP_BRANCH: begin
                b.branch      = 1'b1;
                b.alu_control = ALU_SUB;
                imm           = IMM_B;
                if (f3 == 3'b010 || f3 == 3'b011)
                    ill = 1'b1;
            end
            OP_JAL: begin
                b.reg_write   = 1'b1;
                b.result_src  = RES_PC4;
                b.jump        = 1'b1;
                imm           = IMM_J;
            end
            OP_JALR: begin
                b.reg_write   = 1'b1;
                b.result_src  = RES_PC4;
                b.jalr        = 1'b1;
                b.alu_src_b   = 1'b1;
                if (f3 != 3'b000)
                    ill = 1'b1;
            end
            OP_LUI: begin
                b.reg_write   = 1'b1;
                b.alu_src_b   = 1'b1;
                b.alu_control = ALU_PASSB;
                imm           = IMM_U;
            end
            OP_AUIPC: begin
                b.reg_write   = 1'b1;
                b.alu_src_a   = 1'b1;
                b.alu_src_b   = 1'b1;
                imm           = IMM_U;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            b   = BUBBLE;
            imm = IMM_I;
        end
    end

    assign bundle_o  = b;
    assign imm_src_o = imm;
    assign illegal_o = ill;

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - five-stage control: stage registers, branch resolution, hazards, bypass
module pipeline_control
    import ctrl_pkg::*;
#(
    parameter int FORWARDING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic        ZeroE,
    input  logic        LtE,
    input  logic        LtuE,
    output logic [2:0]  ImmSrcD,
    output logic        IllegalD,
    output logic [3:0]  ALUControlE,
    output logic        ALUSrcAE,
    output logic        ALUSrcBE,
    output logic [1:0]  PCSrcE,
    output logic        MemWriteM,
    output logic [2:0]  AddressingControlM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE
);

    ctrl_bundle_t bundle_d;
    ctrl_bundle_t id_ex_d, id_ex_q;
    mem_ctrl_t    ex_mem_d, ex_mem_q;
    wb_ctrl_t     mem_wb_d, mem_wb_q;

    logic [4:0] rs1_d, rs2_d;
    logic       cond_e, redirect_e, load_use, interlock, hazard_d, flush_e;
    logic [1:0] pc_src_e;

    ctrl_decoder u_decoder (
        .instr_i   (instrD),
        .bundle_o  (bundle_d),
        .imm_src_o (ImmSrcD),
        .illegal_o (IllegalD)
    );

    assign rs1_d = instrD[19:15];
    assign rs2_d = instrD[24:20];

    // Resolve branch condition and select the next-PC source in Execute
    always_comb begin
        case (id_ex_q.funct3)
            3'b000:  cond_e = ZeroE;
            3'b001:  cond_e = !ZeroE;
            3'b100:  cond_e = LtE;
            3'b101:  cond_e = !LtE;
            3'b110:  cond_e = LtuE;
            3'b111:  cond_e = !LtuE;
            default: cond_e = 1'b0;
        endcase
        pc_src_e = PC_PLUS4;
        if (id_ex_q.jalr)
            pc_src_e = PC_ALU;
        else if (id_ex_q.jump || (id_ex_q.branch && cond_e))
            pc_src_e = PC_TARGET;
    end

    assign redirect_e = (pc_src_e != PC_PLUS4);

    // Load-use always stalls; without bypass any in-flight writer of a source stalls
    always_comb begin
        load_use = rd_hits(id_ex_q.result_src == RES_MEM, id_ex_q.rd, rs1_d)
                || rd_hits(id_ex_q.result_src == RES_MEM, id_ex_q.rd, rs2_d);
        interlock = 1'b0;
        if (FORWARDING == 0)
            interlock = rd_hits(id_ex_q.reg_write,  id_ex_q.rd,  rs1_d) || rd_hits(id_ex_q.reg_write,  id_ex_q.rd,  rs2_d)
                     || rd_hits(ex_mem_q.reg_write, ex_mem_q.rd, rs1_d) || rd_hits(ex_mem_q.reg_write, ex_mem_q.rd, rs2_d)
                     || rd_hits(mem_wb_q.reg_write, mem_wb_q.rd, rs1_d) || rd_hits(mem_wb_q.reg_write, mem_wb_q.rd, rs2_d);
        hazard_d = load_use || interlock;
    end

    // A redirect discards the stalled instruction, so it overrides the stall
    assign StallF  = hazard_d && !redirect_e;
    assign StallD  = hazard_d && !redirect_e;
    assign FlushD  = redirect_e;
    assign flush_e = hazard_d || redirect_e;

    // Bypass selection for the Execute operands, M taking priority over W
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (FORWARDING != 0) begin
            if (rd_hits(ex_mem_q.reg_write, ex_mem_q.rd, id_ex_q.rs1))
                ForwardAE = FWD_M;
            else if (rd_hits(mem_wb_q.reg_write, mem_wb_q.rd, id_ex_q.rs1))
                ForwardAE = FWD_W;
            if (rd_hits(ex_mem_q.reg_write, ex_mem_q.rd, id_ex_q.rs2))
                ForwardBE = FWD_M;
            else if (rd_hits(mem_wb_q.reg_write, mem_wb_q.rd, id_ex_q.rs2))
                ForwardBE = FWD_W;
        end
    end

    assign id_ex_d  = flush_e ? BUBBLE : bundle_d;
    assign ex_mem_d = '{id_ex_q.reg_write, id_ex_q.result_src, id_ex_q.mem_write, id_ex_q.funct3, id_ex_q.rd};
    assign mem_wb_d = '{ex_mem_q.reg_write, ex_mem_q.result_src, ex_mem_q.rd};

    // Stage registers; reset clears every stage to a bubble at once so no store can fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q  <= BUBBLE;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign ALUControlE        = id_ex_q.alu_control;
    assign ALUSrcAE           = id_ex_q.alu_src_a;
    assign ALUSrcBE           = id_ex_q.alu_src_b;
    assign PCSrcE             = pc_src_e;
    assign MemWriteM          = ex_mem_q.mem_write;
    assign AddressingControlM = ex_mem_q.funct3;
    assign RegWriteW          = mem_wb_q.reg_write;
    assign ResultSrcW         = mem_wb_q.result_src;

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - directed-vector bench for pipeline_control in both hazard modes
module tb_pipeline_control;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] LUI7   = 32'h123453B7;
    localparam logic [31:0] LW5    = 32'h0000A283;
    localparam logic [31:0] ADD6   = 32'h00228333;
    localparam logic [31:0] LW0    = 32'h0000A003;
    localparam logic [31:0] ADD6X0 = 32'h00200333;
    localparam logic [31:0] ADD3   = 32'h002081B3;
    localparam logic [31:0] SUB4   = 32'h40318233;
    localparam logic [31:0] BEQ    = 32'h00208463;
    localparam logic [31:0] BGE    = 32'h0020D463;
    localparam logic [31:0] BLTU   = 32'h0020E463;
    localparam logic [31:0] JAL1   = 32'h010000EF;
    localparam logic [31:0] JALR0  = 32'h00008067;
    localparam logic [31:0] AUIPC5 = 32'h00000297;
    localparam logic [31:0] SW     = 32'h0020A023;
    localparam logic [31:0] ILL    = 32'hFFFFFFFF;
    localparam logic [31:0] MUL    = 32'h02208333;
    localparam logic [31:0] SRAI   = 32'h4030D093;

    logic        clk, rst, zero_e, lt_e, ltu_e;
    logic [31:0] instr_a, instr_b;

    logic [2:0] imm_a, addr_a, imm_b, addr_b;
    logic       ill_a, srca_a, srcb_a, memw_a, regw_a, stallf_a, stalld_a, flushd_a;
    logic       ill_b, srca_b, srcb_b, memw_b, regw_b, stallf_b, stalld_b, flushd_b;
    logic [3:0] alu_a, alu_b;
    logic [1:0] pcsrc_a, res_a, fwda_a, fwdb_a, pcsrc_b, res_b, fwda_b, fwdb_b;

    int n_vec  = 0;
    int n_miss = 0;
    int n;

    pipeline_control #(.FORWARDING(1)) u_dut (
        .clk(clk), .rst(rst), .instrD(instr_a), .ZeroE(zero_e), .LtE(lt_e), .LtuE(ltu_e),
        .ImmSrcD(imm_a), .IllegalD(ill_a), .ALUControlE(alu_a), .ALUSrcAE(srca_a), .ALUSrcBE(srcb_a),
        .PCSrcE(pcsrc_a), .MemWriteM(memw_a), .AddressingControlM(addr_a), .RegWriteW(regw_a),
        .ResultSrcW(res_a), .StallF(stallf_a), .StallD(stalld_a), .FlushD(flushd_a),
        .ForwardAE(fwda_a), .ForwardBE(fwdb_a)
    );

    pipeline_control #(.FORWARDING(0)) u_dut_il (
        .clk(clk), .rst(rst), .instrD(instr_b), .ZeroE(zero_e), .LtE(lt_e), .LtuE(ltu_e),
        .ImmSrcD(imm_b), .IllegalD(ill_b), .ALUControlE(alu_b), .ALUSrcAE(srca_b), .ALUSrcBE(srcb_b),
        .PCSrcE(pcsrc_b), .MemWriteM(memw_b), .AddressingControlM(addr_b), .RegWriteW(regw_b),
        .ResultSrcW(res_b), .StallF(stallf_b), .StallD(stalld_b), .FlushD(flushd_b),
        .ForwardAE(fwda_b), .ForwardBE(fwdb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_a = NOP; instr_b = NOP;
        zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        instr_a = NOP; instr_b = NOP;
        zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
        step();
        check("rst_e_a",  {alu_a, srca_a, srcb_a, pcsrc_a}, 0);
        check("rst_mw_a", {memw_a, addr_a, regw_a, res_a}, 0);
        check("rst_hz_a", {stallf_a, stalld_a, flushd_a, fwda_a, fwdb_a}, 0);
        check("rst_dec_a", {imm_a, ill_a}, 0);
        check("rst_all_b", {alu_b, srca_b, srcb_b, pcsrc_b, memw_b, addr_b, regw_b, res_b,
                            stallf_b, stalld_b, flushd_b, fwda_b, fwdb_b}, 0);
        check("rst_dec_b", {imm_b, ill_b}, 0);
        rst = 1'b0;

        // lui: U immediate, pass-B in E, writes ALU result in W
        instr_a = LUI7; #1;
        check("lui_imm", imm_a, 3'b100);
        check("lui_ill", ill_a, 0);
        step(); instr_a = NOP; #1;
        check("lui_alu_e", alu_a, 4'b1001);
        check("lui_srcb_e", srcb_a, 1);
        step(); step();
        check("lui_regw_w", regw_a, 1);
        check("lui_res_w", res_a, 2'b00);

        // load-use: one stall cycle, bubble in E, then bypass from W
        do_reset();
        instr_a = LW5; step();
        instr_a = ADD6; #1;
        check("lu_stall", {stallf_a, stalld_a}, 2'b11);
        check("lu_flushd", flushd_a, 0);
        step();
        check("lu_srcb_bubble", srcb_a, 0);
        check("lu_stall_end", {stallf_a, stalld_a}, 2'b00);
        step();
        check("lu_fwda", fwda_a, 2'b01);
        check("lu_fwdb", fwdb_a, 2'b00);
        check("lu_regw_lw", regw_a, 1);
        check("lu_res_lw", res_a, 2'b01);
        step();
        check("lu_regw_bubble", regw_a, 0);
        step();
        check("lu_regw_add", regw_a, 1);

        // load into x0 never stalls
        do_reset();
        instr_a = LW0; step();
        instr_a = ADD6X0; #1;
        check("lu_x0_stall", stalld_a, 0);

        // back-to-back dependency resolved by M bypass on both operands
        do_reset();
        instr_a = ADD3; step();
        instr_a = SUB4; #1;
        check("fw_nostall", stalld_a, 0);
        step();
        check("fw_a_m", fwda_a, 2'b10);
        check("fw_b_m", fwdb_a, 2'b10);
        check("fw_alu_sub", alu_a, 4'b0001);

        // same pair with pure interlock: three stall cycles, no bypass
        do_reset();
        instr_b = ADD3; step();
        instr_b = SUB4; #1;
        n = 0;
        while (stalld_b && n < 8) begin
            n++;
            step();
        end
        check("il_stall_cycles", n, 3);
        step();
        check("il_alu_sub", alu_b, 4'b0001);
        check("il_fwd", {fwda_b, fwdb_b}, 0);

        // redirect wins over an interlock stall
        do_reset();
        instr_b = JAL1; step();
        instr_b = ADD3; #1;
        check("rw_pcsrc", pcsrc_b, 2'b01);
        check("rw_stall", {stallf_b, stalld_b}, 2'b00);
        check("rw_flushd", flushd_b, 1);

        // beq taken / not taken
        do_reset();
        instr_a = BEQ; step();
        instr_a = NOP; zero_e = 1'b1; #1;
        check("beq_t_pcsrc", pcsrc_a, 2'b01);
        check("beq_t_flush", flushd_a, 1);
        zero_e = 1'b0; #1;
        check("beq_nt_pcsrc", pcsrc_a, 2'b00);
        check("beq_nt_flush", flushd_a, 0);

        // bge and bltu conditions
        do_reset();
        instr_a = BGE; step();
        lt_e = 1'b0; #1;
        check("bge_t", pcsrc_a, 2'b01);
        lt_e = 1'b1; #1;
        check("bge_nt", pcsrc_a, 2'b00);
        lt_e = 1'b0;
        do_reset();
        instr_a = BLTU; step();
        ltu_e = 1'b1; #1;
        check("bltu_t", pcsrc_a, 2'b01);
        ltu_e = 1'b0; #1;
        check("bltu_nt", pcsrc_a, 2'b00);

        // jalr selects ALU target and squashes the following instruction
        do_reset();
        instr_a = JALR0; step();
        instr_a = AUIPC5; #1;
        check("jalr_pcsrc", pcsrc_a, 2'b10);
        check("jalr_flush", flushd_a, 1);
        step();
        check("jalr_bubble_srca", srca_a, 0);
        check("jalr_bubble_pcsrc", pcsrc_a, 2'b00);

        // asynchronous reset kills a store sitting in M
        do_reset();
        instr_a = SW; step();
        instr_a = NOP; step();
        check("sw_memw_m", memw_a, 1);
        check("sw_addr_m", addr_a, 3'b010);
        #2 rst = 1'b1;
        #1;
        check("arst_memw", memw_a, 0);
        check("arst_all", {alu_a, srca_a, srcb_a, pcsrc_a, addr_a, regw_a, res_a,
                           stallf_a, stalld_a, flushd_a, fwda_a, fwdb_a}, 0);

        // illegal instruction becomes an all-zero bundle
        do_reset();
        instr_a = AUIPC5; step();
        instr_a = ILL; #1;
        check("auipc_src", {srca_a, srcb_a}, 2'b11);
        check("ill_flag", ill_a, 1);
        step();
        instr_a = NOP;
        check("ill_e_zero", {alu_a, srca_a, srcb_a, pcsrc_a}, 0);
        step();
        check("auipc_regw", regw_a, 1);
        step();
        check("ill_regw_w", regw_a, 0);
        instr_a = MUL; #1;
        check("mul_ill", ill_a, 1);
        instr_a = SRAI; #1;
        check("srai_legal", ill_a, 0);
        step();
        check("srai_alu", alu_a, 4'b1011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
